pc_fetch_unit: RTL and testbench

- Program-counter and fetch-sequencing stage directly upstream of the instruction-memory read block; drives the PC that addresses instruction memory.
- Computes PC+4, BEQ and J targets (8-bit signed word offset), and holds the PC while instruction/data memory asserts BUSYWAIT.
- Redirect decisions taken during a stall are buffered.
- Provides a fetch-valid flag, a one-cycle redirect (flush) pulse and a retired-instruction counter for the memory-hierarchy labs.

---
 rtl/pc_fetch_unit.sv | 107 ++++++++++
 tb/tb_pc_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer feeding instruction memory.
// Holds the PC across memory stalls and replays a redirect decided during the stall.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          OFFSET_W = 8,
   parameter int          CNT_W    = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                busywait,
   input  logic                branch,
   input  logic                zero,
   input  logic                jump,
   input  logic [OFFSET_W-1:0] offset,
   output logic [31:0]         pc,
   output logic [31:0]         pc_next4,
   output logic                fetch_valid,
   output logic                redirect,
   output logic [CNT_W-1:0]    retired
);

   typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;

   state_t      state;
   state_t      state_next;
   logic        taken;
   logic [31:0] offset_ext;
   logic [31:0] target;
   logic        pend_valid;
   logic [31:0] pend_target;
   logic        advance;
   logic        capture;
   logic        redirect_d;
   logic [31:0] pc_d;

   assign taken      = jump | (branch & zero);
   assign pc_next4   = pc + 32'd4;
   assign offset_ext = {{(32-OFFSET_W){offset[OFFSET_W-1]}}, offset};
   assign target     = pc_next4 + {offset_ext[29:0], 2'b00};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= BOOT;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         BOOT:    state_next = RUN;
         RUN:     state_next = busywait ? STALL : RUN;
         STALL:   state_next = busywait ? STALL : RUN;
         default: state_next = BOOT;
      endcase
   end

   // Decide what the next edge does to the PC; a stall in RUN snapshots the redirect.
   always_comb begin
      advance    = 1'b0;
      capture    = 1'b0;
      redirect_d = 1'b0;
      pc_d       = pc_next4;
      case (state)
         RUN: begin
            if (busywait) begin
               capture = 1'b1;
            end else begin
               advance    = 1'b1;
               redirect_d = taken;
               pc_d       = taken ? target : pc_next4;
            end
         end
         STALL: begin
            if (!busywait) begin
               advance    = 1'b1;
               redirect_d = pend_valid;
               pc_d       = pend_valid ? pend_target : pc_next4;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= RESET_PC;
         fetch_valid <= 1'b0;
         redirect    <= 1'b0;
         retired     <= '0;
         pend_valid  <= 1'b0;
         pend_target <= 32'd0;
      end else begin
         redirect    <= redirect_d;
         fetch_valid <= (state_next == RUN);
         if (advance) begin
            pc      <= pc_d;
            retired <= retired + CNT_W'(1);
         end
         if (capture) begin
            pend_valid  <= taken;
            pend_target <= target;
         end else if (advance) begin
            pend_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vector table, hand-written
// reset/wrap sequences, then random stimulus against a behavioural model.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rst2 = 1'b1;
   logic        busywait = 1'b0;
   logic        branch = 1'b0;
   logic        zero = 1'b0;
   logic        jump = 1'b0;
   logic [7:0]  offset = 8'h00;
   logic [31:0] pc, pc_next4, pc2, pc_next4_2;
   logic        fetch_valid, redirect, fetch_valid2, redirect2;
   logic [31:0] retired, retired2;

   int passed = 0;
   int total  = 0;

   // Behavioural reference state
   logic [31:0] m_pc, m_ptarget, m_retired;
   bit          m_booted, m_stalled, m_pend, m_redirect;

   pc_fetch_unit dut (
      .clk(clk), .reset(reset), .busywait(busywait), .branch(branch),
      .zero(zero), .jump(jump), .offset(offset), .pc(pc), .pc_next4(pc_next4),
      .fetch_valid(fetch_valid), .redirect(redirect), .retired(retired)
   );

   pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clk(clk), .reset(rst2), .busywait(busywait), .branch(branch),
      .zero(zero), .jump(jump), .offset(offset), .pc(pc2), .pc_next4(pc_next4_2),
      .fetch_valid(fetch_valid2), .redirect(redirect2), .retired(retired2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        busy, br, z, j;
      logic [7:0]  off;
      logic [31:0] pc;
      logic        redir, valid;
      logic [31:0] ret;
   } vec_t;

   vec_t vecs[19];

   function automatic void modelReset();
      m_pc = 32'h0; m_ptarget = 32'h0; m_retired = 32'h0;
      m_booted = 0; m_stalled = 0; m_pend = 0; m_redirect = 0;
   endfunction

   function automatic void modelStep(bit busy, bit br, bit z, bit j, logic [7:0] off);
      bit          t;
      int          soff;
      logic [31:0] tgt;
      t    = j | (br & z);
      soff = $signed(off);
      tgt  = m_pc + 32'd4 + 32'(soff * 4);
      if (!m_booted) begin
         m_booted   = 1;
         m_redirect = 0;
      end else if (!m_stalled) begin
         if (busy) begin
            m_stalled  = 1;
            m_pend     = t;
            m_ptarget  = tgt;
            m_redirect = 0;
         end else begin
            m_pc       = t ? tgt : m_pc + 32'd4;
            m_retired  = m_retired + 32'd1;
            m_redirect = t;
         end
      end else if (busy) begin
         m_redirect = 0;
      end else begin
         m_pc       = m_pend ? m_ptarget : m_pc + 32'd4;
         m_redirect = m_pend;
         m_retired  = m_retired + 32'd1;
         m_pend     = 0;
         m_stalled  = 0;
      end
   endfunction

   task automatic applyStimulus(input bit busy, input bit br, input bit z,
                                input bit j, input logic [7:0] off);
      busywait = busy; branch = br; zero = z; jump = j; offset = off;
      @(posedge clk);
      #1;
      modelStep(busy, br, z, j, off);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      else
         passed++;
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, " pc"}, pc, m_pc);
      checkOutput({tag, " pc_next4"}, pc_next4, m_pc + 32'd4);
      checkOutput({tag, " redirect"}, {31'd0, redirect}, {31'd0, m_redirect});
      checkOutput({tag, " fetch_valid"}, {31'd0, fetch_valid},
                  {31'd0, m_booted && !m_stalled});
      checkOutput({tag, " retired"}, retired, m_retired);
   endtask

   initial begin
      //            busy  br    z     j     off     pc        redir valid ret
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h00, 1'b0, 1'b1, 32'd0};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h04, 1'b0, 1'b1, 32'd1};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h08, 1'b0, 1'b1, 32'd2};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0C, 1'b0, 1'b1, 32'd3};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h10, 1'b0, 1'b1, 32'd4};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hFE, 32'h0C, 1'b1, 1'b1, 32'd5};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h10, 1'b0, 1'b1, 32'd6};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hFE, 32'h14, 1'b0, 1'b1, 32'd7};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h18, 1'b0, 1'b1, 32'd8};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h1C, 1'b0, 1'b1, 32'd9};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h20, 1'b0, 1'b1, 32'd10};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 32'h20, 1'b0, 1'b0, 32'd10};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h7F, 32'h20, 1'b0, 1'b0, 32'd10};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h7F, 32'h20, 1'b0, 1'b0, 32'd10};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h7F, 32'h30, 1'b1, 1'b1, 32'd11};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 32'h38, 1'b1, 1'b1, 32'd12};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h3C, 1'b0, 1'b1, 32'd13};
      vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h3C, 1'b0, 1'b0, 32'd13};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h40, 1'b0, 1'b1, 32'd14};

      modelReset();
      #1;
      checkOutput("reset pc", pc, 32'h0);
      checkOutput("reset fetch_valid", {31'd0, fetch_valid}, 32'd0);
      checkOutput("reset redirect", {31'd0, redirect}, 32'd0);
      checkOutput("reset retired", retired, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 19; i++) begin
         applyStimulus(vecs[i].busy, vecs[i].br, vecs[i].z, vecs[i].j, vecs[i].off);
         checkOutput($sformatf("vec%0d pc", i), pc, vecs[i].pc);
         checkOutput($sformatf("vec%0d pc_next4", i), pc_next4, vecs[i].pc + 32'd4);
         checkOutput($sformatf("vec%0d redirect", i), {31'd0, redirect}, {31'd0, vecs[i].redir});
         checkOutput($sformatf("vec%0d fetch_valid", i), {31'd0, fetch_valid}, {31'd0, vecs[i].valid});
         checkOutput($sformatf("vec%0d retired", i), retired, vecs[i].ret);
      end

      // Asynchronous reset in the middle of a stall with a pending jump
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h10);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async reset pc", pc, 32'h0);
      checkOutput("async reset retired", retired, 32'd0);
      checkOutput("async reset fetch_valid", {31'd0, fetch_valid}, 32'd0);
      modelReset();
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("post reset pc0", pc, 32'h0);
      checkOutput("post reset valid", {31'd0, fetch_valid}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("post reset pc4", pc, 32'h4);
      checkOutput("post reset redirect", {31'd0, redirect}, 32'd0);
      checkOutput("post reset retired", retired, 32'd1);

      // PC wrap-around on the instance reset to 0xFFFF_FFF8
      checkOutput("wrap reset pc", pc2, 32'hFFFF_FFF8);
      @(negedge clk);
      rst2 = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("wrap pc0", pc2, 32'hFFFF_FFF8);
      checkOutput("wrap next4 0", pc_next4_2, 32'hFFFF_FFFC);
      checkOutput("wrap valid", {31'd0, fetch_valid2}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("wrap pc1", pc2, 32'hFFFF_FFFC);
      checkOutput("wrap next4 1", pc_next4_2, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("wrap pc2", pc2, 32'h0);
      checkOutput("wrap redirect", {31'd0, redirect2}, 32'd0);
      checkOutput("wrap retired", retired2, 32'd2);

      // Random stimulus against the reference model
      for (int n = 0; n < 400; n++) begin
         applyStimulus($urandom_range(0, 9) < 3, 1'($urandom), 1'($urandom),
                       $urandom_range(0, 5) == 0, 8'($urandom));
         checkModel($sformatf("rand%0d", n));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
